// File: rtl/uart_reg_pkg.sv
// Shared constants, state encoding and timeout arithmetic for the UART register responder.
package uart_reg_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_ACK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR  = 8'h45;  // 'E'

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StAccess,
    StLoad,
    StSend,
    StWaitDone
  } state_e;

  // Kind of frame currently being handled; selects the bus strobe and the reply byte.
  typedef enum logic [1:0] {
    OpWrite,
    OpRead,
    OpError
  } op_e;

  // Inter-byte timeout in clock cycles: n_bytes byte times of 10 bit periods each.
  // Never returns 0 so the counter always has a reachable terminal value.
  function automatic int unsigned timeout_limit(input int unsigned sys_freq,
                                                input int unsigned baud_rate,
                                                input int unsigned n_bytes);
    logic [63:0] cycles;
    cycles = (64'(n_bytes) * 64'd10 * 64'(sys_freq)) / 64'(baud_rate);
    if (cycles == 64'd0) begin
      cycles = 64'd1;
    end
    return 32'(cycles);
  endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Saturating inter-byte gap counter; expired goes high once LIMIT cycles have been counted.
module uart_frame_timeout #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clock,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntWidth = $clog2(LIMIT) + 1;
  // The count seen on the LIMIT-th enabled cycle after a clear.
  localparam logic [CntWidth-1:0] LastCount = CntWidth'(LIMIT - 1);

  logic [CntWidth-1:0] count_q;

  // Clear wins over counting; the counter parks at all-ones instead of wrapping.
  always_ff @(posedge clock) begin
    if (srst || clear) begin
      count_q <= '0;
    end else if (enable && (count_q != '1)) begin
      count_q <= count_q + CntWidth'(1);
    end
  end

  assign expired = (count_q >= LastCount);

endmodule

// File: rtl/uart_reg_responder.sv
// Host command responder: parses W/R frames from the UART byte stream, drives an 8-bit
// register bus and returns one reply byte per frame.
module uart_reg_responder
  import uart_reg_pkg::*;
#(
  parameter int unsigned SYSTEM_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE     = 9600,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic                  clock,
  input  logic                  srst,
  input  logic [7:0]            rx_value,
  input  logic                  rx_value_ready,
  output logic [7:0]            tx_value,
  output logic                  tx_value_write,
  input  logic                  tx_value_done,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]            reg_wdata,
  output logic                  reg_write,
  output logic                  reg_read,
  input  logic [7:0]            reg_rdata,
  output logic                  busy,
  output logic                  frame_error,
  output logic                  rx_dropped
);

  localparam int unsigned TimeoutLimit = timeout_limit(SYSTEM_FREQ, BAUD_RATE, TIMEOUT_BYTES);

  state_e                state_q, state_d;
  op_e                   op_q;
  logic [ADDR_WIDTH-1:0] reg_addr_q;
  logic [7:0]            reg_wdata_q;
  logic [7:0]            tx_value_q;
  logic                  rx_dropped_q;

  logic in_frame;
  logic byte_accepted;
  logic byte_dropped;
  logic timeout_expired;
  logic timeout_fire;

  assign in_frame      = (state_q == StGetAddr) || (state_q == StGetData);
  assign byte_accepted = rx_value_ready && ((state_q == StIdle) || in_frame);
  assign byte_dropped  = rx_value_ready && !((state_q == StIdle) || in_frame);
  // A byte arriving on the expiry cycle still counts; only a silent line times out.
  assign timeout_fire  = in_frame && timeout_expired && !rx_value_ready;

  uart_frame_timeout #(
    .LIMIT (TimeoutLimit)
  ) u_timeout (
    .clock   (clock),
    .srst    (srst),
    .clear   (byte_accepted),
    .enable  (in_frame),
    .expired (timeout_expired)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (srst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: parse bytes, run the bus cycle, then hand one reply to the transmitter.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rx_value_ready) begin
          state_d = ((rx_value == OP_WRITE) || (rx_value == OP_READ)) ? StGetAddr : StLoad;
        end
      end
      StGetAddr: begin
        if (rx_value_ready) begin
          state_d = (op_q == OpWrite) ? StGetData : StAccess;
        end else if (timeout_fire) begin
          state_d = StIdle;
        end
      end
      StGetData: begin
        if (rx_value_ready) begin
          state_d = StAccess;
        end else if (timeout_fire) begin
          state_d = StIdle;
        end
      end
      StAccess: state_d = StLoad;
      StLoad:   state_d = StSend;
      StSend:   state_d = StWaitDone;
      // A done strobe during StSend is not looked at, so it cannot end the reply early.
      StWaitDone: begin
        if (tx_value_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes and status decoded from the current state.
  always_comb begin
    reg_write      = 1'b0;
    reg_read       = 1'b0;
    tx_value_write = 1'b0;
    busy           = (state_q != StIdle);
    frame_error    = timeout_fire;
    unique case (state_q)
      StAccess: begin
        reg_write = (op_q == OpWrite);
        reg_read  = (op_q == OpRead);
      end
      StLoad:  frame_error = (op_q == OpError);
      StSend:  tx_value_write = 1'b1;
      default: ;
    endcase
  end

  // Frame fields, reply byte and the sticky drop flag.
  always_ff @(posedge clock) begin
    if (srst) begin
      op_q         <= OpError;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      tx_value_q   <= '0;
      rx_dropped_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rx_value_ready) begin
            if (rx_value == OP_WRITE) begin
              op_q <= OpWrite;
            end else if (rx_value == OP_READ) begin
              op_q <= OpRead;
            end else begin
              op_q <= OpError;
            end
          end
        end
        StGetAddr: begin
          if (rx_value_ready) begin
            reg_addr_q <= rx_value[ADDR_WIDTH-1:0];
          end
        end
        StGetData: begin
          if (rx_value_ready) begin
            reg_wdata_q <= rx_value;
          end
        end
        // reg_rdata is valid here, one cycle after the read strobe in StAccess.
        StLoad: begin
          unique case (op_q)
            OpWrite: tx_value_q <= RSP_ACK;
            OpRead:  tx_value_q <= reg_rdata;
            default: tx_value_q <= RSP_ERR;
          endcase
        end
        default: ;
      endcase
      if (byte_dropped) begin
        rx_dropped_q <= 1'b1;
      end
    end
  end

  assign reg_addr   = reg_addr_q;
  assign reg_wdata  = reg_wdata_q;
  assign tx_value   = tx_value_q;
  assign rx_dropped = rx_dropped_q;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Byte-level bench for uart_reg_responder: host frames in, a 256x8 register target on the
// bus, a transmitter stand-in acknowledging replies, and a frame-level reference model.
module tb_uart_reg_responder;

  localparam int SysFreq      = 1000;
  localparam int Baud         = 100;
  localparam int TimeoutBytes = 4;
  localparam int ByteCycles   = 10 * SysFreq / Baud;
  localparam int LimitCycles  = TimeoutBytes * ByteCycles;

  logic       clock = 1'b0;
  logic       srst = 1'b1;
  logic [7:0] rx_value = 8'h00;
  logic       rx_value_ready = 1'b0;
  logic [7:0] tx_value;
  logic       tx_value_write;
  logic       tx_value_done = 1'b0;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_write;
  logic       reg_read;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       frame_error;
  logic       rx_dropped;

  logic [7:0] slave_mem [256];  // bus target the DUT talks to
  logic [7:0] ref_mem   [256];  // what the host believes the registers hold

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int n_wr = 0;
  int n_rd = 0;
  int n_ferr = 0;
  int n_txw = 0;
  int last_wr_cyc = 0;
  int last_rd_cyc = 0;
  int last_ferr_cyc = 0;
  int last_rx_cyc = 0;
  bit both_high = 1'b0;

  uart_reg_responder #(
    .SYSTEM_FREQ   (SysFreq),
    .BAUD_RATE     (Baud),
    .ADDR_WIDTH    (8),
    .TIMEOUT_BYTES (TimeoutBytes)
  ) dut (
    .clock          (clock),
    .srst           (srst),
    .rx_value       (rx_value),
    .rx_value_ready (rx_value_ready),
    .tx_value       (tx_value),
    .tx_value_write (tx_value_write),
    .tx_value_done  (tx_value_done),
    .reg_addr       (reg_addr),
    .reg_wdata      (reg_wdata),
    .reg_write      (reg_write),
    .reg_read       (reg_read),
    .reg_rdata      (reg_rdata),
    .busy           (busy),
    .frame_error    (frame_error),
    .rx_dropped     (rx_dropped)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  assign reg_rdata = slave_mem[reg_addr];

  // Bus target and strobe bookkeeping, sampled mid-cycle.
  always @(negedge clock) begin
    if (reg_write) begin
      n_wr <= n_wr + 1;
      last_wr_cyc <= cyc;
      slave_mem[reg_addr] <= reg_wdata;
    end
    if (reg_read) begin
      n_rd <= n_rd + 1;
      last_rd_cyc <= cyc;
    end
    if (frame_error) begin
      n_ferr <= n_ferr + 1;
      last_ferr_cyc <= cyc;
    end
    if (tx_value_write) n_txw <= n_txw + 1;
    if (reg_write && reg_read) both_high <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic pulse_byte(input logic [7:0] b);
    @(posedge clock);
    #1;
    rx_value = b;
    rx_value_ready = 1'b1;
    @(negedge clock);
    last_rx_cyc = cyc;
    @(posedge clock);
    #1;
    rx_value_ready = 1'b0;
  endtask

  task automatic wait_reply(output bit got, output logic [7:0] val, output int at);
    got = 1'b0;
    val = 8'h00;
    at = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      if (tx_value_write) begin
        got = 1'b1;
        val = tx_value;
        at = cyc;
      end
    end
  endtask

  // One complete frame; expectations come from the frame rules, not from the DUT.
  task automatic run_frame(input logic [7:0] op, input logic [7:0] addr,
                           input logic [7:0] data, input bit inject);
    int wr0, rd0, fe0, tx0, at, t_last, lat;
    int exp_wr, exp_rd, exp_fe;
    bit got;
    logic [7:0] val, exp_reply;
    wr0 = n_wr; rd0 = n_rd; fe0 = n_ferr; tx0 = n_txw;
    exp_wr = 0; exp_rd = 0; exp_fe = 0;
    if (op == 8'h57) begin
      exp_reply = 8'h4B; exp_wr = 1; lat = 3;
      ref_mem[addr] = data;
    end else if (op == 8'h52) begin
      exp_reply = ref_mem[addr]; exp_rd = 1; lat = 3;
    end else begin
      exp_reply = 8'h45; exp_fe = 1; lat = 2;
    end
    pulse_byte(op);
    if (exp_wr == 1 || exp_rd == 1) begin
      idle($urandom_range(0, 20));
      pulse_byte(addr);
    end
    if (exp_wr == 1) begin
      idle($urandom_range(0, 20));
      pulse_byte(data);
    end
    t_last = last_rx_cyc;
    wait_reply(got, val, at);
    check("reply_seen", 32'(got), 1);
    if (got) begin
      check("reply_value", 32'(val), 32'(exp_reply));
      check("reply_latency", at - t_last, lat);
    end
    if (inject) pulse_byte(8'h52);
    idle($urandom_range(0, 10));
    @(posedge clock);
    #1 tx_value_done = 1'b1;
    @(posedge clock);
    #1 tx_value_done = 1'b0;
    @(negedge clock);
    #1;
    check("idle_after_reply", 32'(busy), 0);
    check("write_count", n_wr - wr0, exp_wr);
    check("read_count", n_rd - rd0, exp_rd);
    check("frame_error_count", n_ferr - fe0, exp_fe);
    check("reply_count", n_txw - tx0, 1);
    if (exp_wr == 1) begin
      check("write_strobe_latency", last_wr_cyc - t_last, 1);
      check("reg_wdata_hold", 32'(reg_wdata), 32'(data));
    end
    if (exp_rd == 1) check("read_strobe_latency", last_rd_cyc - t_last, 1);
    if (exp_wr == 1 || exp_rd == 1) check("reg_addr_hold", 32'(reg_addr), 32'(addr));
    if (exp_fe == 1) check("error_pulse_latency", last_ferr_cyc - t_last, 1);
    if (inject) check("rx_dropped_set", 32'(rx_dropped), 1);
  endtask

  task automatic run_timeout();
    int wr0, rd0, fe0, tx0, t0, at;
    bit got;
    wr0 = n_wr; rd0 = n_rd; fe0 = n_ferr; tx0 = n_txw;
    pulse_byte(8'h57);
    t0 = last_rx_cyc;
    got = 1'b0;
    at = 0;
    for (int i = 0; i < LimitCycles + 20 && !got; i++) begin
      @(negedge clock);
      if (frame_error) begin
        got = 1'b1;
        at = cyc;
      end
    end
    check("timeout_seen", 32'(got), 1);
    check("timeout_latency", at - t0, LimitCycles);
    idle(5 * ByteCycles - LimitCycles);
    @(negedge clock);
    #1;
    check("timeout_idle", 32'(busy), 0);
    check("timeout_error_count", n_ferr - fe0, 1);
    check("timeout_no_bus", (n_wr - wr0) + (n_rd - rd0), 0);
    check("timeout_no_reply", n_txw - tx0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, %0d checks done", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] op, addr, data;
    int r;
    for (int i = 0; i < 256; i++) begin
      data = 8'($urandom);
      slave_mem[i] = data;
      ref_mem[i] = data;
    end

    // Reset state.
    repeat (3) @(posedge clock);
    #1 srst = 1'b0;
    @(negedge clock);
    check("reset_busy", 32'(busy), 0);
    check("reset_strobes", 32'({tx_value_write, reg_write, reg_read, frame_error}), 0);
    check("reset_regs", 32'({tx_value, reg_addr, reg_wdata, rx_dropped}), 0);

    // Directed frames.
    run_frame(8'h57, 8'h10, 8'hA5, 1'b0);
    run_frame(8'h52, 8'h10, 8'h00, 1'b0);
    run_frame(8'h00, 8'h00, 8'h00, 1'b0);
    run_frame(8'h52, 8'h10, 8'h00, 1'b0);

    // Inter-byte timeout, then a clean write.
    run_timeout();
    run_frame(8'h57, 8'h20, 8'h3C, 1'b0);

    // Byte arriving while the reply is outstanding.
    check("rx_dropped_clear", 32'(rx_dropped), 0);
    run_frame(8'h52, 8'h10, 8'h00, 1'b1);

    // Synchronous reset in the middle of a write frame.
    pulse_byte(8'h57);
    idle(2);
    pulse_byte(8'h33);
    idle(3);
    @(posedge clock);
    #1 srst = 1'b1;
    @(posedge clock);
    #1 srst = 1'b0;
    @(negedge clock);
    check("srst_outputs", 32'({tx_value, tx_value_write, reg_addr, reg_wdata, reg_write,
                               reg_read, busy, frame_error, rx_dropped}), 0);
    run_frame(8'h52, 8'h20, 8'h00, 1'b0);

    // Randomized frames over a small address window so reads hit earlier writes.
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 9));
      addr = 8'h40 + 8'($urandom_range(0, 7));
      data = 8'($urandom);
      if (r < 4) begin
        op = 8'h57;
      end else if (r < 8) begin
        op = 8'h52;
      end else begin
        op = 8'($urandom);
        while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
      end
      run_frame(op, addr, data, ($urandom_range(0, 4) == 0));
    end

    check("write_read_exclusive", 32'(both_high), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_reg_responder.md
Name: uart_reg_responder

Overview:
- Command responder on the byte side of simple_uart: parses host frames from rx_value/rx_value_ready and drives a simple 8-bit register bus.
- Returns one reply byte per frame through tx_value/tx_value_write/tx_value_done.
- Lets a host PC, acting as the protocol initiator, peek and poke on-chip registers over the same 8N1 link.

Parameters:
SYSTEM_FREQ, 50_000_000, clock frequency in Hz
BAUD_RATE, 9600, link baud rate; used only for the timeout
ADDR_WIDTH, 8, register address width (1..8); the low ADDR_WIDTH bits of the address byte are used
TIMEOUT_BYTES, 4, maximum inter-byte gap inside a frame, in byte times (1 byte time = 10*SYSTEM_FREQ/BAUD_RATE cycles)

Ports:
clock  in  1  system clock
srst  in  1  synchronous active-high reset
rx_value  in  8  received byte from simple_uart
rx_value_ready  in  1  1-cycle strobe: rx_value valid
tx_value  out  8  reply byte to simple_uart (registered)
tx_value_write  out  1  1-cycle strobe: send tx_value
tx_value_done  in  1  1-cycle strobe: transmitter finished the byte
reg_addr  out  ADDR_WIDTH  register address (registered)
reg_wdata  out  8  write data (registered)
reg_write  out  1  1-cycle write strobe
reg_read  out  1  1-cycle read strobe
reg_rdata  in  8  read data, valid the cycle after reg_read
busy  out  1  high in any state other than IDLE
frame_error  out  1  1-cycle pulse on bad opcode or timeout
rx_dropped  out  1  sticky: a byte arrived while replying; cleared only by srst

Behaviour:
- One clock; reset is synchronous and active-high (port srst, sampled on posedge clock). srst overrides everything, including mid-frame and mid-reply.
- Reset values: every output 0, state IDLE, timeout counter 0.
- Frames:
  - Write: 0x57 'W', addr, data -> reply 0x4B 'K'.
  - Read: 0x52 'R', addr -> reply = reg_rdata.
  - Any other first byte: reply 0x45 'E'.
- States: IDLE, GET_ADDR, GET_DATA, ACCESS, LOAD, SEND, WAIT_DONE.
- IDLE, on rx_value_ready:
  - 'W' or 'R' -> GET_ADDR, latch opcode.
  - Other byte -> LOAD with reply 0x45; frame_error pulses in the LOAD cycle.
- GET_ADDR, on a byte: latch reg_addr. 'W' -> GET_DATA; 'R' -> ACCESS.
- GET_DATA, on a byte: latch reg_wdata -> ACCESS.
- ACCESS: exactly one cycle with reg_write=1 (W) or reg_read=1 (R) -> LOAD.
- LOAD: tx_value <= reg_rdata (R), 0x4B (W) or 0x45 (error) -> SEND.
- SEND: tx_value_write=1 for one cycle -> WAIT_DONE.
- WAIT_DONE, on tx_value_done -> IDLE. A tx_value_done arriving in the same cycle as SEND is ignored.
- Latency:
  - Last frame byte strobed at cycle N: strobe at N+1, tx_value_write at N+3.
  - Bad opcode at N: tx_value_write at N+2.
- Timeout:
  - Counter clears on every accepted byte and counts only in GET_ADDR and GET_DATA.
  - At TIMEOUT_BYTES*10*SYSTEM_FREQ/BAUD_RATE cycles: pulse frame_error, go IDLE, send no reply, assert no bus strobe.
  - Counter width is $clog2 of the limit plus 1; it saturates and never wraps.
- A byte with rx_value_ready in ACCESS, LOAD, SEND or WAIT_DONE is discarded and sets rx_dropped. It is never parsed as a new opcode.
- reg_write and reg_read are never high together. reg_addr and reg_wdata hold their values until the next frame.

Decomposition:
- Package uart_reg_pkg holds:
  - opcode constants OP_WRITE=8'h57, OP_READ=8'h52;
  - reply constants RSP_ACK=8'h4B, RSP_ERR=8'h45;
  - the state enum encoding;
  - the timeout-limit function of SYSTEM_FREQ, BAUD_RATE and TIMEOUT_BYTES.
- One natural sub-module, uart_frame_timeout: a saturating counter with clear/enable inputs and an expired output.
- Bench: pair with simple_uart (SYSTEM_FREQ=50_000_000, BAUD_RATE=9600), a host-side serial driver/sampler, and a 256x8 register model.

Test Plan:
- Send 57 10 A5 -> exactly one reg_write with reg_addr=0x10, reg_wdata=0xA5; tx_value_write with 0x4B 3 cycles after the last rx_value_ready; host samples 0x4B.
- After the previous case, send 52 10 -> one reg_read with reg_addr=0x10; host receives 0xA5; no reg_write.
- Send 00 -> frame_error pulse, host receives 0x45, no bus strobe; a following 52 10 still returns 0xA5.
- Send 57, then hold the line idle for 5 byte times -> frame_error at exactly the timeout limit, no reply, busy low; a following 57 20 3C writes 0x3C to 0x20.
- Inject rx_value_ready=1, rx_value=0x52 during WAIT_DONE -> rx_dropped=1, no extra reg_read, exactly one reply byte.
- Assert srst for one cycle in GET_DATA -> next cycle all outputs 0 and IDLE; a following 52 20 returns the register model's value.
